// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator for the yadan fetch stage
// Sequential advance with end-of-space wrap, trap/branch redirects, one-deep redirect buffer while fetch is off.
module pc_gen #(
   parameter int unsigned        ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]  START_ADDR = 32'h0000_0000,
   parameter logic [ADDR_W-1:0]  END_ADDR   = 32'h0000_FFFC,
   parameter int unsigned        STALL_W    = 5,
   parameter bit                 C_EXT      = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               trap_flag_i,
   input  logic [ADDR_W-1:0]  trap_addr_i,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_addr_i,
   input  logic [STALL_W-1:0] stalled_i,
   input  logic               fetch_gnt_i,
   input  logic               step_half_i,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               ce_o,
   output logic               fetch_req_o,
   output logic               redirect_o,
   output logic               wrap_o,
   output logic               misalign_o
);

   typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

   localparam logic [ADDR_W-1:0] LOW_MASK = C_EXT ? ADDR_W'(1) : ADDR_W'(3);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              pend_is_trap_q, pend_is_trap_d;
   logic              redirect_q, redirect_d;
   logic              wrap_q, wrap_d;
   logic              misalign_q, misalign_d;

   logic              fresh_req;
   logic [ADDR_W-1:0] fresh_tgt;
   logic [ADDR_W-1:0] fresh_aligned;
   logic              fresh_mis;
   logic [ADDR_W-1:0] step;
   logic              advance;
   logic              unused_stall;

   // Trap outranks branch whenever both are presented in the same cycle.
   assign fresh_req     = trap_flag_i | branch_flag_i;
   assign fresh_tgt     = trap_flag_i ? trap_addr_i : branch_addr_i;
   assign fresh_aligned = fresh_tgt & ~LOW_MASK;
   assign fresh_mis     = |(fresh_tgt & LOW_MASK);
   assign step          = (C_EXT && step_half_i) ? ADDR_W'(2) : ADDR_W'(4);
   assign advance       = en_i & ~stalled_i[0] & fetch_gnt_i;
   assign unused_stall  = ^stalled_i;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      pend_addr_d    = pend_addr_q;
      pend_is_trap_d = pend_is_trap_q;
      redirect_d     = 1'b0;
      wrap_d         = 1'b0;
      misalign_d     = 1'b0;
      case (state_q)
         PEND: begin
            if (en_i) begin
               // A fresh redirect supersedes the buffered one; stall never blocks the load.
               pc_d           = fresh_req ? fresh_aligned : pend_addr_q;
               misalign_d     = fresh_req & fresh_mis;
               redirect_d     = 1'b1;
               pend_addr_d    = '0;
               pend_is_trap_d = 1'b0;
               state_d        = RUN;
            end else if (trap_flag_i | (branch_flag_i & ~pend_is_trap_q)) begin
               pend_addr_d    = fresh_aligned;
               pend_is_trap_d = trap_flag_i;
               misalign_d     = fresh_mis;
            end
         end
         default: begin
            state_d = RUN;
            if (fresh_req) begin
               misalign_d = fresh_mis;
               if (en_i) begin
                  pc_d       = fresh_aligned;
                  redirect_d = 1'b1;
               end else begin
                  pend_addr_d    = fresh_aligned;
                  pend_is_trap_d = trap_flag_i;
                  state_d        = PEND;
               end
            end else if (state_q == RUN && advance) begin
               if (pc_q >= END_ADDR) begin
                  pc_d   = START_ADDR;
                  wrap_d = 1'b1;
               end else begin
                  pc_d = pc_q + step;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= BOOT;
         pc_q           <= START_ADDR;
         pend_addr_q    <= '0;
         pend_is_trap_q <= 1'b0;
         redirect_q     <= 1'b0;
         wrap_q         <= 1'b0;
         misalign_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         pend_addr_q    <= pend_addr_d;
         pend_is_trap_q <= pend_is_trap_d;
         redirect_q     <= redirect_d;
         wrap_q         <= wrap_d;
         misalign_q     <= misalign_d;
      end
   end

   assign pc_o        = pc_q;
   assign ce_o        = en_i;
   assign fetch_req_o = en_i & ~stalled_i[0] & (state_q != BOOT);
   assign redirect_o  = redirect_q;
   assign wrap_o      = wrap_q;
   assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen with a behavioural reference model
// Two instances (C_EXT=1 and C_EXT=0) share stimulus; directed scenarios then randomized traffic.
module tb_pc_gen;

   localparam logic [31:0] START = 32'h0000_0000;
   localparam logic [31:0] ENDA  = 32'h0000_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b1;
   logic        trap = 1'b0;
   logic [31:0] trap_addr = '0;
   logic        branch = 1'b0;
   logic [31:0] branch_addr = '0;
   logic [4:0]  stall = '0;
   logic        gnt = 1'b1;
   logic        half = 1'b0;

   logic [31:0] pc0, pc1;
   logic        ce0, ce1, fr0, fr1, rd0, rd1, wr0, wr1, mi0, mi1;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference state per instance: index 0 has compressed support, index 1 does not.
   logic [31:0] m_pc [2];
   logic        m_boot [2];
   logic        m_pend_v [2];
   logic [31:0] m_pend_a [2];
   logic        m_pend_t [2];
   logic        m_redir [2];
   logic        m_wrap [2];
   logic        m_mis [2];

   always #5 clk = ~clk;

   pc_gen #(.ADDR_W(32), .START_ADDR(START), .END_ADDR(ENDA), .STALL_W(5), .C_EXT(1'b1)) u_c (
      .clk(clk), .rst(rst), .en_i(en), .trap_flag_i(trap), .trap_addr_i(trap_addr),
      .branch_flag_i(branch), .branch_addr_i(branch_addr), .stalled_i(stall),
      .fetch_gnt_i(gnt), .step_half_i(half), .pc_o(pc0), .ce_o(ce0), .fetch_req_o(fr0),
      .redirect_o(rd0), .wrap_o(wr0), .misalign_o(mi0));

   pc_gen #(.ADDR_W(32), .START_ADDR(START), .END_ADDR(ENDA), .STALL_W(5), .C_EXT(1'b0)) u_n (
      .clk(clk), .rst(rst), .en_i(en), .trap_flag_i(trap), .trap_addr_i(trap_addr),
      .branch_flag_i(branch), .branch_addr_i(branch_addr), .stalled_i(stall),
      .fetch_gnt_i(gnt), .step_half_i(half), .pc_o(pc1), .ce_o(ce1), .fetch_req_o(fr1),
      .redirect_o(rd1), .wrap_o(wr1), .misalign_o(mi1));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic m_fr(input int k);
      return en & ~stall[0] & ~m_boot[k];
   endfunction

   task automatic model_step(input int k);
      logic [31:0] keep;
      logic [31:0] tgt;
      logic        mis;
      keep = (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
      tgt  = trap ? trap_addr : branch_addr;
      mis  = (tgt & ~keep) != 0;
      m_redir[k] = 1'b0;
      m_wrap[k]  = 1'b0;
      m_mis[k]   = 1'b0;
      if (m_pend_v[k]) begin
         if (en) begin
            m_pc[k]     = (trap | branch) ? (tgt & keep) : m_pend_a[k];
            m_mis[k]    = (trap | branch) & mis;
            m_redir[k]  = 1'b1;
            m_pend_v[k] = 1'b0;
         end else if (trap || (branch && !m_pend_t[k])) begin
            m_pend_a[k] = tgt & keep;
            m_pend_t[k] = trap;
            m_mis[k]    = mis;
         end
      end else if (trap | branch) begin
         m_mis[k] = mis;
         if (en) begin
            m_pc[k]    = tgt & keep;
            m_redir[k] = 1'b1;
         end else begin
            m_pend_v[k] = 1'b1;
            m_pend_a[k] = tgt & keep;
            m_pend_t[k] = trap;
         end
      end else if (!m_boot[k] && en && !stall[0] && gnt) begin
         if (m_pc[k] >= ENDA) begin
            m_pc[k]   = START;
            m_wrap[k] = 1'b1;
         end else begin
            m_pc[k] = m_pc[k] + ((k == 0 && half) ? 32'd2 : 32'd4);
         end
      end
      m_boot[k] = 1'b0;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            m_pc[k] = START; m_boot[k] = 1'b1; m_pend_v[k] = 1'b0;
            m_pend_a[k] = '0; m_pend_t[k] = 1'b0;
            m_redir[k] = 1'b0; m_wrap[k] = 1'b0; m_mis[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   task automatic cmp_dut(input int k, input logic [31:0] pc, input logic ce, input logic fr,
                          input logic rd, input logic wr, input logic mi);
      chk($sformatf("pc_o[%0d]", k), pc, m_pc[k]);
      chk($sformatf("ce_o[%0d]", k), {31'd0, ce}, {31'd0, en});
      chk($sformatf("fetch_req_o[%0d]", k), {31'd0, fr}, {31'd0, m_fr(k)});
      chk($sformatf("redirect_o[%0d]", k), {31'd0, rd}, {31'd0, m_redir[k]});
      chk($sformatf("wrap_o[%0d]", k), {31'd0, wr}, {31'd0, m_wrap[k]});
      chk($sformatf("misalign_o[%0d]", k), {31'd0, mi}, {31'd0, m_mis[k]});
   endtask

   always @(negedge clk) begin
      cmp_dut(0, pc0, ce0, fr0, rd0, wr0, mi0);
      cmp_dut(1, pc1, ce1, fr1, rd1, wr1, mi1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 2))
         0:       return $urandom;
         1:       return 32'h0000_FFE0 + 32'($urandom_range(0, 31));
         default: return 32'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      tick(); tick();
      rst = 1'b1;
      chk("boot_pc", m_pc[0], 32'h0);
      chk("boot_fetch_req", {31'd0, m_fr(0)}, 32'd0);
      tick(); chk("seq_pc1", m_pc[0], 32'h0);
      tick(); chk("seq_pc2", m_pc[0], 32'h4);
      tick(); chk("seq_pc3", m_pc[0], 32'h8);

      branch = 1'b1; branch_addr = 32'hFFF8;
      tick(); branch = 1'b0;
      tick(); chk("pre_wrap_pc", m_pc[0], 32'hFFFC);
      tick(); chk("wrap_pc", m_pc[0], 32'h0); chk("wrap_pulse", {31'd0, m_wrap[0]}, 32'd1);
      tick(); chk("wrap_pulse_end", {31'd0, m_wrap[0]}, 32'd0);

      branch = 1'b1; branch_addr = 32'h10;
      tick(); branch = 1'b0; half = 1'b1;
      tick(); half = 1'b0;
      chk("half_step_c", m_pc[0], 32'h12);
      chk("half_step_noc", m_pc[1], 32'h14);

      trap = 1'b1; trap_addr = 32'h100; branch = 1'b1; branch_addr = 32'h200; stall = 5'h01;
      tick(); trap = 1'b0; branch = 1'b0; stall = '0;
      chk("prio_pc", m_pc[0], 32'h100); chk("prio_redirect", {31'd0, m_redir[0]}, 32'd1);

      en = 1'b0; branch = 1'b1; branch_addr = 32'h300;
      tick(); branch = 1'b0; trap = 1'b1; trap_addr = 32'h400;
      tick(); trap = 1'b0; branch = 1'b1; branch_addr = 32'h500;
      tick(); branch = 1'b0; en = 1'b1;
      tick();
      chk("pend_pc", m_pc[0], 32'h400);
      chk("pend_redirect", {31'd0, m_redir[0]}, 32'd1);
      chk("pend_empty", {31'd0, m_pend_v[0]}, 32'd0);

      branch = 1'b1; branch_addr = 32'h203;
      tick(); branch = 1'b0;
      chk("mis_pc_c", m_pc[0], 32'h202); chk("mis_pc_noc", m_pc[1], 32'h200);
      chk("mis_pulse_c", {31'd0, m_mis[0]}, 32'd1); chk("mis_pulse_noc", {31'd0, m_mis[1]}, 32'd1);

      en = 1'b0; branch = 1'b1; branch_addr = 32'h600;
      tick(); branch = 1'b0;
      chk("pend_buf", m_pend_a[0], 32'h600);
      #2 rst = 1'b0;
      #1 chk("async_rst_pc", m_pc[0], START);
      @(posedge clk); #1 rst = 1'b1; en = 1'b1;
      tick(); chk("lost_buf_redirect", {31'd0, m_redir[0]}, 32'd0); chk("lost_buf_pc", m_pc[0], 32'h0);
      tick(); chk("lost_buf_pc2", m_pc[0], 32'h4);

      for (int i = 0; i < 3000; i++) begin
         en          = $urandom_range(0, 9) < 7;
         trap        = $urandom_range(0, 15) == 0;
         branch      = $urandom_range(0, 7) == 0;
         trap_addr   = rand_addr();
         branch_addr = rand_addr();
         stall       = 5'($urandom);
         gnt         = $urandom_range(0, 3) != 0;
         half        = $urandom_range(0, 1) == 1;
         rst         = $urandom_range(0, 299) != 0;
         tick();
      end
      rst = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
